mux_16_1_rr: RTL and testbench
==============================

# mux_16_1_rr

Sequential 16-to-1 merge: collects W-bit words from 16 source channels and forwards them, one per cycle, onto a single output stream. Each word is tagged with its 4-bit source index. It is the return path paired with the 1-to-16 demultiplexer, which steers one word out to one of 16 destinations. Channels are served by round-robin arbitration and held in a one-entry output register with a valid/ready handshake on every side.

## Interface
Parameters:
- W, 16, data width per channel.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  16*W  channel i data in bits [i*W +: W].
- in_valid  in  16  bit i: channel i offers a word.
- in_ready  out  16  bit i: channel i word accepted this cycle (one-hot or zero).
- out_data  out  W  forwarded word (registered).
- out_sel  out  4  source channel of out_data (registered).
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts the word this cycle.

## Operation
- States: EMPTY (out_valid=0) and FULL (out_valid=1). No other state besides the 4-bit round-robin pointer ptr.
- The load enable is computed as follows:
  - ld = (|in_valid) && (!out_valid || out_ready).
  - The output register loads whenever ld is 1.
- Grant g is the first i with in_valid[i]=1, searching ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- in_ready[i] = ld && (i == g). This is combinational and may depend on out_ready in the same cycle.
- On ld, the register updates as follows:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g+1 (mod 16; 15 wraps to 0).
- When out_valid && out_ready && !(|in_valid): out_valid <= 0. out_data and out_sel keep their values.
- When FULL and out_ready=0: out_data, out_sel and out_valid are held stable, and in_ready = 0.
- A source keeps its word and in_valid asserted until in_ready is seen. The block never drops or duplicates a word.
- The transfer rules are:
  - Input transfer on channel i is in_valid[i] && in_ready[i].
  - Output transfer is out_valid && out_ready.
- Simultaneous output transfer and new load in one cycle: the new word replaces the old one, giving 1 word/cycle sustained throughput.

## Timing
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 during reset.
  - This applies mid-transfer: a word held in the register is discarded.
- Latency: a word accepted at edge k appears on out_data/out_valid right after edge k (1 cycle).
- Throughput: 1 word/cycle when out_ready is held high and any in_valid is set.
- Fairness: with all 16 channels valid and out_ready=1, grants go ptr, ptr+1, … and each channel is served once every 16 cycles.
- Idle with no valid input: ptr is unchanged.

## Structure
- Shared package mux_pkg:
  - N_CH=16 and SEL_W=4.
  - The state encoding, EMPTY=1'b0 and FULL=1'b1.
- Sub-module rr_arbiter_16:
  - Inputs: req[15:0], ptr[3:0], en.
  - Outputs: grant one-hot[15:0], gidx[3:0], any.
  - Purely combinational.
  - The pointer register lives in the top level.
- The top level holds the output register, the ptr register and the handshake logic.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles with in_valid=16'hFFFF. Require out_valid=0, out_data=0, out_sel=0, in_ready=0. After release with in_valid=0, out_valid stays 0.
- Single channel: in_valid=16'h0020 with in_data[5]=16'hA5A5 and out_ready=1. Require in_ready=16'h0020 in that cycle; next cycle out_valid=1, out_data=16'hA5A5, out_sel=5.
- Round robin: all 16 valid with in_data[i]=i and out_ready=1 for 20 cycles from reset. Require out_sel sequence 0,1,…,15,0,1,2,3 and out_data equal to out_sel.
- Backpressure: register FULL with out_sel=3 and out_ready=0 for 5 cycles while channels 7 and 9 are valid. Require out_data/out_sel stable and in_ready=0. When out_ready rises, require same-cycle in_ready[7]=1 and next out_sel=7.
- Wrap-around: ptr=15 after granting 14, then in_valid=16'h8001. Require grant 15 next, then 0.
- Reset mid-stream: assert rst_n=0 while FULL with out_sel=9. Require out_valid=0 and ptr=0 after the edge. On restart with channels 0 and 9 valid, the first grant is 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 16-to-1 round-robin merge.
package mux_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Round-robin pointer advance: the channel after the granted one, wrapping 15 -> 0.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_16.sv
// Combinational round-robin arbiter over 16 requesters. The search starts
// at ptr and wraps; the pointer register itself is owned by the caller.
module rr_arbiter_16
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] gidx,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Kept separate from the search so callers may fold 'any' into 'en' without a loop.
  assign any = |req;

  // First requester at or after ptr (mod 16); one-hot grant only when enabled.
  always_comb begin
    grant = 16'h0000;
    gidx  = 4'd0;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + k[SEL_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end else begin
        found = found;
      end
    end
    if (en && found) begin
      grant[gidx] = 1'b1;
    end else begin
      grant = 16'h0000;
    end
  end

endmodule

// File: rtl/mux_16_1_rr.sv
// 16-to-1 merge with round-robin arbitration into a one-entry output
// register. Each forwarded word carries its 4-bit source index.
module mux_16_1_rr
  import mux_pkg::*;
#(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic             any;
  logic             ld;

  assign out_valid = (state_r == FULL);

  // Load when something is offered and the register is empty or draining this
  // cycle; held off during reset so no source believes its word was taken.
  assign ld = rst_n && any && (!out_valid || out_ready);

  assign in_ready = grant;

  rr_arbiter_16 u_arb (
    .req   (in_valid),
    .ptr   (ptr_r),
    .en    (ld),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // Output register, occupancy state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      out_data <= '0;
      out_sel  <= 4'd0;
      ptr_r    <= 4'd0;
    end else if (ld) begin
      state_r  <= FULL;
      out_data <= in_data[gidx*W +: W];
      out_sel  <= gidx;
      ptr_r    <= next_ptr(gidx);
    end else if (out_valid && out_ready) begin
      state_r  <= EMPTY;
    end else begin
      state_r  <= state_r;
    end
  end

endmodule

// File: tb/tb_mux_16_1_rr.sv
// Scoreboard bench for mux_16_1_rr: directed stimulus pushes hand-computed
// {sel,data} words; a negedge monitor pops on every output transfer.
module tb_mux_16_1_rr;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic [16*W-1:0] in_data;
  logic [15:0]   in_valid;
  logic [15:0]   in_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_sel;
  logic          out_valid;
  logic          out_ready;

  int total;
  int bad;
  logic [19:0] exp_q[$];

  mux_16_1_rr #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] sel, input logic [15:0] data);
    exp_q.push_back({sel, data});
  endtask

  task automatic set_ch(input int ch, input logic [15:0] val);
    in_data[ch*W +: W] = val;
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got sel=%0d data=%0h expected none", out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sel", {28'd0, out_sel}, {28'd0, e[19:16]});
        chk("sb_data", {16'd0, out_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    in_data   = '0;
    in_valid  = 16'h0000;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset with every channel requesting: nothing may be accepted.
    in_valid = 16'hFFFF;
    #1;
    chk("rst_in_ready", {16'd0, in_ready}, 32'h0);
    cyc();
    cyc();
    chk("rst_in_ready2", {16'd0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_out_data", {16'd0, out_data}, 32'h0);
    chk("rst_out_sel", {28'd0, out_sel}, 32'h0);
    rst_n    = 1'b1;
    in_valid = 16'h0000;
    cyc();
    cyc();
    chk("idle_out_valid", {31'd0, out_valid}, 32'h0);

    // Single channel 5.
    set_ch(5, 16'hA5A5);
    in_valid = 16'h0020;
    #1;
    chk("single_in_ready", {16'd0, in_ready}, 32'h0020);
    push(4'd5, 16'hA5A5);
    cyc();
    in_valid = 16'h0000;
    chk("single_valid", {31'd0, out_valid}, 32'h1);
    chk("single_data", {16'd0, out_data}, 32'hA5A5);
    chk("single_sel", {28'd0, out_sel}, 32'd5);
    cyc();
    chk("single_drain", {31'd0, out_valid}, 32'h0);

    // Round robin from reset: 20 consecutive grants 0..15,0..3.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) set_ch(i, 16'(i));
    in_valid = 16'hFFFF;
    for (int k = 0; k < 20; k++) begin
      push(4'(k % 16), 16'(k % 16));
      cyc();
      chk("rr_sel", {28'd0, out_sel}, 32'(k % 16));
    end
    in_valid = 16'h0000;
    cyc();

    // Backpressure: hold sel 3 while 7 and 9 wait (ptr is 4).
    set_ch(3, 16'h0333);
    set_ch(7, 16'h0777);
    set_ch(9, 16'h0999);
    in_valid  = 16'h0008;
    out_ready = 1'b0;
    push(4'd3, 16'h0333);
    cyc();
    in_valid = 16'h0280;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", {16'd0, in_ready}, 32'h0);
      chk("bp_sel", {28'd0, out_sel}, 32'd3);
      chk("bp_data", {16'd0, out_data}, 32'h0333);
      chk("bp_valid", {31'd0, out_valid}, 32'h1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {16'd0, in_ready}, 32'h0080);
    push(4'd7, 16'h0777);
    cyc();
    in_valid = 16'h0200;
    chk("bp_next_sel", {28'd0, out_sel}, 32'd7);
    push(4'd9, 16'h0999);
    cyc();
    in_valid = 16'h0000;
    chk("bp_then9", {28'd0, out_sel}, 32'd9);
    cyc();

    // Wrap-around: grant 14 leaves ptr=15, then 15 before 0.
    set_ch(14, 16'hEEEE);
    set_ch(15, 16'hFFFF);
    set_ch(0, 16'h1111);
    in_valid = 16'h4000;
    push(4'd14, 16'hEEEE);
    cyc();
    in_valid = 16'h8001;
    #1;
    chk("wrap_ready15", {16'd0, in_ready}, 32'h8000);
    push(4'd15, 16'hFFFF);
    cyc();
    chk("wrap_sel15", {28'd0, out_sel}, 32'd15);
    in_valid = 16'h0001;
    #1;
    chk("wrap_ready0", {16'd0, in_ready}, 32'h0001);
    push(4'd0, 16'h1111);
    cyc();
    chk("wrap_sel0", {28'd0, out_sel}, 32'd0);
    in_valid = 16'h0000;
    cyc();

    // Reset mid-stream with sel 9 held: the word is discarded.
    set_ch(9, 16'h9999);
    in_valid  = 16'h0200;
    out_ready = 1'b0;
    cyc();
    chk("mid_full_sel", {28'd0, out_sel}, 32'd9);
    in_valid = 16'h0000;
    rst_n    = 1'b0;
    cyc();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'h0);
    chk("mid_rst_sel", {28'd0, out_sel}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_ch(0, 16'h0A0A);
    in_valid = 16'h0201;
    #1;
    chk("mid_restart_ready", {16'd0, in_ready}, 32'h0001);
    push(4'd0, 16'h0A0A);
    cyc();
    in_valid = 16'h0200;
    push(4'd9, 16'h9999);
    cyc();
    in_valid = 16'h0000;
    cyc();

    // Pointer reset: after granting 3 (ptr=4), reset must return the search to 0.
    set_ch(3, 16'h0333);
    in_valid  = 16'h0008;
    out_ready = 1'b0;
    cyc();
    in_valid = 16'h0000;
    rst_n    = 1'b0;
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_ch(0, 16'h0C0C);
    in_valid = 16'h0009;
    #1;
    chk("ptr_rst_ready", {16'd0, in_ready}, 32'h0001);
    push(4'd0, 16'h0C0C);
    cyc();
    in_valid = 16'h0008;
    push(4'd3, 16'h0333);
    cyc();
    in_valid = 16'h0000;
    cyc();
    cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
